// File: rtl/alu_secuenciador_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, FSM encoding, flag layout
// and the flag-capture helper.
package alu_pkg;

    localparam int N_DEF = 3;

    localparam logic [3:0] OP_SUMA    = 4'd0;
    localparam logic [3:0] OP_RESTA   = 4'd1;
    localparam logic [3:0] OP_INC     = 4'd2;
    localparam logic [3:0] OP_DEC     = 4'd3;
    localparam logic [3:0] OP_AND     = 4'd4;
    localparam logic [3:0] OP_OR      = 4'd5;
    localparam logic [3:0] OP_NOT     = 4'd6;
    localparam logic [3:0] OP_XOR     = 4'd7;
    localparam logic [3:0] OP_SHL     = 4'd8;
    localparam logic [3:0] OP_SHR     = 4'd9;
    localparam logic [3:0] OP_RES_MIN = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int FLG_ZERO = 0;
    localparam int FLG_NEG  = 1;
    localparam int FLG_COUT = 2;
    localparam int FLG_OVF  = 3;

    function automatic logic op_reserved(input logic [3:0] op);
        return (op >= OP_RES_MIN);
    endfunction

    // The ALU leaves cout/overflow undefined for RESTA and DEC, so they are masked.
    function automatic logic [3:0] pack_flags(input logic ovf, input logic cout,
                                              input logic neg, input logic zero,
                                              input logic [3:0] op);
        logic       undef;
        logic [3:0] f;
        undef       = (op == OP_RESTA) || (op == OP_DEC);
        f           = 4'b0000;
        f[FLG_OVF]  = ovf & ~undef;
        f[FLG_COUT] = cout & ~undef;
        f[FLG_NEG]  = neg;
        f[FLG_ZERO] = zero;
        return f;
    endfunction

endpackage

// File: rtl/alu_secuenciador_if.sv
// Request, response and ALU-side signals of the sequencer; slave is the
// sequencer view, master is the surrounding logic (requesters, consumer, ALU).
interface alu_secuenciador_if
    import alu_pkg::*;
#(
    parameter int N = N_DEF
);
    logic         req0_valid, req0_ready, req0_flagin;
    logic [3:0]   req0_op;
    logic [N-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready, req1_flagin;
    logic [3:0]   req1_op;
    logic [N-1:0] req1_a, req1_b;

    logic         resp_valid, resp_ready, resp_id, resp_err;
    logic [N-1:0] resp_resultado;
    logic [3:0]   resp_flags;

    logic [N-1:0] alu_a, alu_b, alu_resultado;
    logic [3:0]   alu_select;
    logic         alu_flagin, alu_negativo, alu_zero, alu_cout, alu_overflow;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b, req0_flagin,
        input  req1_valid, req1_op, req1_a, req1_b, req1_flagin,
        output req0_ready, req1_ready,
        output resp_valid, resp_id, resp_err, resp_resultado, resp_flags,
        input  resp_ready,
        output alu_a, alu_b, alu_select, alu_flagin,
        input  alu_resultado, alu_negativo, alu_zero, alu_cout, alu_overflow
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b, req0_flagin,
        output req1_valid, req1_op, req1_a, req1_b, req1_flagin,
        input  req0_ready, req1_ready,
        input  resp_valid, resp_id, resp_err, resp_resultado, resp_flags,
        output resp_ready,
        input  alu_a, alu_b, alu_select, alu_flagin,
        output alu_resultado, alu_negativo, alu_zero, alu_cout, alu_overflow
    );
endinterface

// File: rtl/alu_secuenciador_rr_arbitro.sv
// Two-way round-robin arbiter; the pointer names the requester favoured
// when both are valid and moves to the loser on every advance.
module rr_arbitro (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant
);
    logic ptr_r;

    // Grant decode from the valid pair and the pointer.
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr_r ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_r <= 1'b0;
        end else if (advance) begin
            ptr_r <= grant[0];
        end else begin
            ptr_r <= ptr_r;
        end
    end
endmodule

// File: rtl/alu_secuenciador.sv
// Shares one external combinational ALU between two requesters: arbitrate,
// drive registered operands, wait SETTLE cycles, return a tagged response.
module alu_secuenciador
    import alu_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int SETTLE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_secuenciador_if.slave  bus
);
    localparam logic [3:0] LAST_CNT = 4'(SETTLE - 1);

    state_t       state_r, state_s;
    logic [1:0]   valid_s, grant_s, ready_s;
    logic         accept_s;
    logic [3:0]   sel_op_s;
    logic [N-1:0] sel_a_s, sel_b_s;
    logic         sel_fi_s;

    logic [3:0]   cnt_r, op_r, alu_sel_r, resp_flags_r;
    logic [N-1:0] alu_a_r, alu_b_r, resp_res_r;
    logic         alu_fi_r, resp_valid_r, resp_id_r, resp_err_r;

    assign valid_s  = {bus.req1_valid, bus.req0_valid};
    assign ready_s  = (rst_n && state_r == ST_IDLE) ? grant_s : 2'b00;
    assign accept_s = |ready_s;

    rr_arbitro u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid   (valid_s),
        .advance (accept_s),
        .grant   (grant_s)
    );

    // Payload of the granted requester.
    always_comb begin
        sel_op_s = bus.req0_op;
        sel_a_s  = bus.req0_a;
        sel_b_s  = bus.req0_b;
        sel_fi_s = bus.req0_flagin;
        if (grant_s[1]) begin
            sel_op_s = bus.req1_op;
            sel_a_s  = bus.req1_a;
            sel_b_s  = bus.req1_b;
            sel_fi_s = bus.req1_flagin;
        end else begin
            sel_op_s = bus.req0_op;
        end
    end

    // Next-state logic; reserved opcodes skip the ALU entirely.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = op_reserved(sel_op_s) ? ST_RESP : ST_EXEC;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (cnt_r == LAST_CNT) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_EXEC;
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_r <= ST_IDLE;
        else        state_r <= state_s;
    end

    // Operand, counter and response registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r        <= 4'd0;
            op_r         <= 4'd0;
            alu_a_r      <= '0;
            alu_b_r      <= '0;
            alu_sel_r    <= 4'd0;
            alu_fi_r     <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_id_r    <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_res_r   <= '0;
            resp_flags_r <= 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        resp_id_r <= grant_s[1];
                        op_r      <= sel_op_s;
                        if (op_reserved(sel_op_s)) begin
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= 1'b1;
                            resp_res_r   <= '0;
                            resp_flags_r <= 4'd0;
                        end else begin
                            alu_a_r   <= sel_a_s;
                            alu_b_r   <= sel_b_s;
                            alu_sel_r <= sel_op_s;
                            alu_fi_r  <= sel_fi_s;
                            cnt_r     <= 4'd0;
                        end
                    end
                end
                ST_EXEC: begin
                    cnt_r <= cnt_r + 4'd1;
                    if (cnt_r == LAST_CNT) begin
                        resp_valid_r <= 1'b1;
                        resp_err_r   <= 1'b0;
                        resp_res_r   <= bus.alu_resultado;
                        resp_flags_r <= pack_flags(bus.alu_overflow, bus.alu_cout,
                                                   bus.alu_negativo, bus.alu_zero, op_r);
                    end
                end
                ST_RESP: begin
                    if (bus.resp_ready) resp_valid_r <= 1'b0;
                end
                default: resp_valid_r <= 1'b0;
            endcase
        end
    end

    assign bus.req0_ready     = ready_s[0];
    assign bus.req1_ready     = ready_s[1];
    assign bus.resp_valid     = resp_valid_r;
    assign bus.resp_id        = resp_id_r;
    assign bus.resp_err       = resp_err_r;
    assign bus.resp_resultado = resp_res_r;
    assign bus.resp_flags     = resp_flags_r;
    assign bus.alu_a          = alu_a_r;
    assign bus.alu_b          = alu_b_r;
    assign bus.alu_select     = alu_sel_r;
    assign bus.alu_flagin     = alu_fi_r;
endmodule

// File: tb/tb_alu_secuenciador.sv
// Bench for alu_secuenciador: a behavioural ALU stand-in plus a transaction-level
// model of arbitration order, latency and captured response contents.
module tb_alu_secuenciador;
    import alu_pkg::*;

    localparam int N      = 3;
    localparam int SETTLE = 1;

    logic clk = 1'b0;
    logic rst_n;
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   model_ptr = 0;
    logic [3:0] last_sel = 4'd0;

    always #5 clk = ~clk;

    alu_secuenciador_if #(.N(N)) bus ();

    alu_secuenciador #(.N(N), .SETTLE(SETTLE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ALU: returns {overflow, cout, negativo, zero, resultado}.
    function automatic logic [N+3:0] alu_fn(input logic [3:0] op, input logic [N-1:0] a,
                                            input logic [N-1:0] b, input logic fi);
        logic [N:0]   w;
        logic [N-1:0] r;
        logic         c, v;
        w = '0; r = '0; c = 1'b0; v = 1'b0;
        case (op)
            OP_SUMA:  begin w = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, fi}; r = w[N-1:0]; c = w[N]; v = c; end
            OP_RESTA: begin w = {1'b0, a} - {1'b0, b} - {{N{1'b0}}, fi}; r = w[N-1:0]; c = w[N]; v = c; end
            OP_INC:   begin w = {1'b0, a} + {{N{1'b0}}, 1'b1}; r = w[N-1:0]; c = w[N]; v = c; end
            OP_DEC:   begin w = {1'b0, a} - {{N{1'b0}}, 1'b1}; r = w[N-1:0]; c = w[N]; v = c; end
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_NOT:   r = ~a;
            OP_XOR:   r = a ^ b;
            OP_SHL:   begin r = {a[N-2:0], fi}; c = a[N-1]; end
            OP_SHR:   begin r = {fi, a[N-1:1]}; c = a[0]; end
            default:  r = '0;
        endcase
        return {v, c, r[N-1], (r == '0), r};
    endfunction

    always_comb begin
        {bus.alu_overflow, bus.alu_cout, bus.alu_negativo, bus.alu_zero, bus.alu_resultado} =
            alu_fn(bus.alu_select, bus.alu_a, bus.alu_b, bus.alu_flagin);
    end

    // Expected {err, flags, resultado} for one request.
    function automatic logic [N+4:0] exp_resp(input logic [3:0] op, input logic [N-1:0] a,
                                              input logic [N-1:0] b, input logic fi);
        logic [N+3:0] t;
        if (op >= 4'd10) return {1'b1, 4'd0, {N{1'b0}}};
        t = alu_fn(op, a, b, fi);
        if (op == 4'd1 || op == 4'd3) t[N+3:N+2] = 2'b00;
        return {1'b0, t};
    endfunction

    task automatic set_req(input int who, input logic v, input logic [3:0] op,
                           input logic [N-1:0] a, input logic [N-1:0] b, input logic fi);
        if (who == 0) begin
            bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req0_flagin = fi;
        end else begin
            bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; bus.req1_flagin = fi;
        end
    endtask

    // One request from a single requester; returns latency and {id, err, flags, res}.
    task automatic xact(input int who, input logic [3:0] op, input logic [N-1:0] a,
                        input logic [N-1:0] b, input logic fi,
                        output int lat, output logic [N+5:0] got, output bit ok);
        @(negedge clk);
        bus.resp_ready = 1'b1;
        set_req(who, 1'b1, op, a, b, fi);
        ok = 1'b0; lat = 0; got = '0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if ((who == 0) ? bus.req0_ready : bus.req1_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            set_req(who, 1'b0, 4'd0, '0, '0, 1'b0);
            return;
        end
        @(posedge clk);
        @(negedge clk);
        set_req(who, 1'b0, 4'd0, '0, '0, 1'b0);
        ok = 1'b0; lat = 1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.resp_valid) begin ok = 1'b1; break; end
            @(negedge clk);
            lat++;
        end
        got = {bus.resp_id, bus.resp_err, bus.resp_flags, bus.resp_resultado};
        if (ok) @(posedge clk);
        model_ptr = 1 - who;
        if (op < 4'd10) last_sel = op;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_req(0, 1'b1, 4'($urandom), N'($urandom), N'($urandom), 1'($urandom));
        set_req(1, 1'b1, 4'($urandom), N'($urandom), N'($urandom), 1'($urandom));
        repeat (3) @(negedge clk);
        #1;
        total_cnt++; if (bus.req0_ready !== 1'b0) $display("FAIL reset_ready0 got %b exp 0", bus.req0_ready); else pass_cnt++;
        total_cnt++; if (bus.req1_ready !== 1'b0) $display("FAIL reset_ready1 got %b exp 0", bus.req1_ready); else pass_cnt++;
        total_cnt++; if (bus.resp_valid !== 1'b0) $display("FAIL reset_resp_valid got %b exp 0", bus.resp_valid); else pass_cnt++;
        total_cnt++; if (bus.alu_select !== 4'd0) $display("FAIL reset_alu_select got %0d exp 0", bus.alu_select); else pass_cnt++;
        rst_n = 1'b1;
        #1;
        total_cnt++; if ({bus.req1_ready, bus.req0_ready} !== 2'b01)
            $display("FAIL reset_first_grant got %b exp 01", {bus.req1_ready, bus.req0_ready}); else pass_cnt++;
        set_req(0, 1'b0, 4'd0, '0, '0, 1'b0);
        set_req(1, 1'b0, 4'd0, '0, '0, 1'b0);
        model_ptr = 0;
    endtask

    task automatic test_fixed_ops();
        int lat; logic [N+5:0] got; bit ok;
        xact(0, 4'd0, 3'd3, 3'd5, 1'b0, lat, got, ok);
        total_cnt++; if (!ok || lat != SETTLE + 1) $display("FAIL suma_latency got %0d ok %0d exp %0d", lat, ok, SETTLE + 1); else pass_cnt++;
        total_cnt++; if (got !== {1'b0, 1'b0, 4'b1101, 3'd0}) $display("FAIL suma_resp got %h exp %h", got, {1'b0, 1'b0, 4'b1101, 3'd0}); else pass_cnt++;
        xact(1, 4'd1, 3'd2, 3'd5, 1'b0, lat, got, ok);
        total_cnt++; if (!ok || lat != SETTLE + 1) $display("FAIL resta_latency got %0d ok %0d exp %0d", lat, ok, SETTLE + 1); else pass_cnt++;
        total_cnt++; if (got !== {1'b1, 1'b0, 4'b0010, 3'd5}) $display("FAIL resta_resp got %h exp %h", got, {1'b1, 1'b0, 4'b0010, 3'd5}); else pass_cnt++;
    endtask

    task automatic test_reserved();
        int lat; logic [N+5:0] got; bit ok; logic [3:0] sel_before;
        sel_before = last_sel;
        xact(0, 4'd12, N'($urandom), N'($urandom), 1'($urandom), lat, got, ok);
        total_cnt++; if (!ok || lat != 1) $display("FAIL err_latency got %0d ok %0d exp 1", lat, ok); else pass_cnt++;
        total_cnt++; if (got !== {1'b0, 1'b1, 4'd0, 3'd0}) $display("FAIL err_resp got %h exp %h", got, {1'b0, 1'b1, 4'd0, 3'd0}); else pass_cnt++;
        total_cnt++; if (bus.alu_select !== sel_before) $display("FAIL err_alu_select got %0d exp %0d", bus.alu_select, sel_before); else pass_cnt++;
    endtask

    task automatic test_random_single();
        int lat; logic [N+5:0] got; bit ok;
        int who; logic [3:0] op; logic [N-1:0] a, b; logic fi;
        for (int k = 0; k < 12; k++) begin
            who = int'($urandom_range(0, 1));
            op = 4'($urandom_range(0, 15)); a = N'($urandom); b = N'($urandom); fi = 1'($urandom);
            xact(who, op, a, b, fi, lat, got, ok);
            total_cnt++; if (!ok || lat != ((op >= 4'd10) ? 1 : SETTLE + 1))
                $display("FAIL rand_latency op %0d got %0d ok %0d", op, lat, ok); else pass_cnt++;
            total_cnt++; if (got !== {1'(who), exp_resp(op, a, b, fi)})
                $display("FAIL rand_resp op %0d a %0d b %0d fi %0d got %h exp %h", op, a, b, fi, got, {1'(who), exp_resp(op, a, b, fi)}); else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] p_op [2]; logic [N-1:0] p_a [2]; logic [N-1:0] p_b [2]; logic p_fi [2];
        logic [N+5:0] q[$]; logic [N+5:0] e;
        bit regen [2]; int exp_who, last_acc, nacc, who;
        exp_who = model_ptr; last_acc = -1; nacc = 0;
        @(negedge clk);
        bus.resp_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            p_op[i] = 4'($urandom_range(0, 9)); p_a[i] = N'($urandom); p_b[i] = N'($urandom); p_fi[i] = 1'($urandom);
            set_req(i, 1'b1, p_op[i], p_a[i], p_b[i], p_fi[i]);
            regen[i] = 1'b0;
        end
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (cyc > 0) @(negedge clk);
            for (int i = 0; i < 2; i++) if (regen[i]) begin
                p_op[i] = 4'($urandom_range(0, 9)); p_a[i] = N'($urandom); p_b[i] = N'($urandom); p_fi[i] = 1'($urandom);
                set_req(i, 1'b1, p_op[i], p_a[i], p_b[i], p_fi[i]);
                regen[i] = 1'b0;
            end
            #1;
            if (bus.resp_valid) begin
                e = (q.size() > 0) ? q.pop_front() : '1;
                total_cnt++; if ({bus.resp_id, bus.resp_err, bus.resp_flags, bus.resp_resultado} !== e)
                    $display("FAIL b2b_resp got %h exp %h", {bus.resp_id, bus.resp_err, bus.resp_flags, bus.resp_resultado}, e); else pass_cnt++;
            end
            if (bus.req0_ready || bus.req1_ready) begin
                who = bus.req1_ready ? 1 : 0;
                total_cnt++; if ({bus.req1_ready, bus.req0_ready} !== ((exp_who == 1) ? 2'b10 : 2'b01))
                    $display("FAIL b2b_grant got %b exp who %0d", {bus.req1_ready, bus.req0_ready}, exp_who); else pass_cnt++;
                if (last_acc >= 0) begin
                    total_cnt++; if (cyc - last_acc != SETTLE + 2)
                        $display("FAIL b2b_interval got %0d exp %0d", cyc - last_acc, SETTLE + 2); else pass_cnt++;
                end
                last_acc = cyc;
                q.push_back({1'(who), exp_resp(p_op[who], p_a[who], p_b[who], p_fi[who])});
                last_sel = p_op[who];
                exp_who = 1 - who; regen[who] = 1'b1; nacc++;
            end
        end
        @(negedge clk);
        set_req(0, 1'b0, 4'd0, '0, '0, 1'b0);
        set_req(1, 1'b0, 4'd0, '0, '0, 1'b0);
        for (int cyc = 0; cyc < 8; cyc++) begin
            #1;
            if (bus.resp_valid) begin
                e = (q.size() > 0) ? q.pop_front() : '1;
                total_cnt++; if ({bus.resp_id, bus.resp_err, bus.resp_flags, bus.resp_resultado} !== e)
                    $display("FAIL b2b_drain got %h exp %h", {bus.resp_id, bus.resp_err, bus.resp_flags, bus.resp_resultado}, e); else pass_cnt++;
            end
            @(negedge clk);
        end
        total_cnt++; if (q.size() != 0 || nacc < 12) $display("FAIL b2b_count left %0d accepted %0d", q.size(), nacc); else pass_cnt++;
        model_ptr = exp_who;
    endtask

    task automatic test_stall_reset();
        logic [3:0] op; logic [N-1:0] a, b; logic fi; logic [N+5:0] e; bit ok;
        op = 4'($urandom_range(0, 9)); a = N'($urandom); b = N'($urandom); fi = 1'($urandom);
        e = {1'b1, exp_resp(op, a, b, fi)};
        @(negedge clk);
        bus.resp_ready = 1'b0;
        set_req(1, 1'b1, op, a, b, fi);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin #1; if (bus.req1_ready) begin ok = 1'b1; break; end @(negedge clk); end
        @(posedge clk);
        @(negedge clk);
        set_req(1, 1'b1, 4'($urandom_range(0, 9)), N'($urandom), N'($urandom), 1'($urandom));
        for (int i = 0; i < 20; i++) begin #1; if (bus.resp_valid) break; @(negedge clk); end
        total_cnt++; if (!ok || bus.resp_valid !== 1'b1) $display("FAIL stall_setup ok %0d resp_valid %b", ok, bus.resp_valid); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            total_cnt++; if (bus.resp_valid !== 1'b1) $display("FAIL stall_valid got %b exp 1", bus.resp_valid); else pass_cnt++;
            total_cnt++; if ({bus.resp_id, bus.resp_err, bus.resp_flags, bus.resp_resultado} !== e)
                $display("FAIL stall_resp got %h exp %h", {bus.resp_id, bus.resp_err, bus.resp_flags, bus.resp_resultado}, e); else pass_cnt++;
            total_cnt++; if (bus.req1_ready !== 1'b0) $display("FAIL stall_req1_ready got %b exp 0", bus.req1_ready); else pass_cnt++;
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk); #1;
        total_cnt++; if (bus.req1_ready !== 1'b1) $display("FAIL stall_regrant got %b exp 1", bus.req1_ready); else pass_cnt++;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        set_req(0, 1'b1, 4'd4, N'($urandom), N'($urandom), 1'b0);
        @(negedge clk); #1;
        total_cnt++; if (bus.resp_valid !== 1'b0 || bus.alu_select !== 4'd0)
            $display("FAIL exec_reset resp_valid %b alu_select %0d exp 0 0", bus.resp_valid, bus.alu_select); else pass_cnt++;
        rst_n = 1'b1;
        #1;
        total_cnt++; if ({bus.req1_ready, bus.req0_ready} !== 2'b01)
            $display("FAIL exec_reset_ptr got %b exp 01", {bus.req1_ready, bus.req0_ready}); else pass_cnt++;
        set_req(0, 1'b0, 4'd0, '0, '0, 1'b0);
        set_req(1, 1'b0, 4'd0, '0, '0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.resp_ready = 1'b0;
        set_req(0, 1'b0, 4'd0, '0, '0, 1'b0);
        set_req(1, 1'b0, 4'd0, '0, '0, 1'b0);
        test_reset();
        test_fixed_ops();
        test_reserved();
        test_random_single();
        test_back_to_back();
        test_stall_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d of %0d passed", pass_cnt, total_cnt);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/alu_secuenciador.md
Name: alu_secuenciador

Overview:
- Two-requester scheduler that shares one combinational ALU (4-bit select, N-bit A/B, flagin; outputs result, negativo, zero, cout, overflow).
- Arbitrates round-robin, drives the ALU operands from registers, and waits a configurable settle time.
- Captures result and flags into registers and returns a tagged response over a valid/ready handshake.
- Sits between instruction-issue logic and the ALU; the ALU is instantiated outside this block.

Parameters:
- N, 3, operand/result width; must match the ALU.
- SETTLE, 1, EXEC cycles before capture (1..15).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset, synchronous, active-low.
- req0_valid / req1_valid  in  1  request present.
- req0_ready / req1_ready  out  1  request accepted this cycle.
- req0_op / req1_op  in  4  ALU select code.
- req0_a, req0_b / req1_a, req1_b  in  N  operands.
- req0_flagin / req1_flagin  in  1  ALU flagin.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts response.
- resp_id  out  1  requester index, 0 or 1.
- resp_resultado  out  N  captured result.
- resp_flags  out  4  {overflow, cout, negativo, zero}.
- resp_err  out  1  reserved opcode (10..15).
- alu_a, alu_b  out  N  registered ALU operands.
- alu_select  out  4  registered ALU select.
- alu_flagin  out  1  registered ALU flagin.
- alu_resultado  in  N  ALU result.
- alu_negativo, alu_zero, alu_cout, alu_overflow  in  1  ALU flags.

Behaviour:
- Reset is synchronous: on a clk edge with rst_n=0, all outputs and registers go to 0; state=IDLE; rr pointer=0 (req0 favoured). This applies in any state and discards any in-flight operation and response.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - reqX_ready = (state==IDLE) & grantX, combinational; at most one ready high.
  - Accept = valid & ready.
  - Only one request valid → grant it. Both valid → grant the one pointed to by rr pointer.
  - Pointer is set to the non-granted index after every accept.
- Accept, op ≤ 9:
  - Register alu_a/alu_b/alu_select/alu_flagin and the id; zero the EXEC counter; go to EXEC.
  - alu_* outputs hold their value until the next accept.
- Accept, op ≥ 10:
  - No ALU drive; alu_* keep their previous values.
  - Go straight to RESP with resp_err=1, resultado=0, flags=0.
- EXEC:
  - Count up to SETTLE cycles.
  - On the last EXEC cycle, sample alu_resultado and flags into the resp registers; go to RESP.
  - For op 1 and op 3, captured cout and overflow are forced to 0 (the ALU does not define them for these ops).
  - For ops 4..9, flags are captured as presented.
- RESP:
  - resp_valid=1; all resp_* stay stable until resp_ready=1.
  - On the handshake cycle: go to IDLE, clear resp_valid.
  - No accept is possible in the same cycle; the next accept is earliest one cycle later.
- Latency:
  - Accept at edge t → resp_valid from edge t+SETTLE+1.
  - Error path → resp_valid from edge t+1.
  - Throughput: one op per SETTLE+2 cycles when resp_ready is held at 1.
- Requesters must hold valid and payload stable until ready. No payload is read outside the accept cycle.
- No back-to-back fairness loss: if a requester deasserts valid, the other may be granted consecutively.

Decomposition:
- Shared package alu_pkg holds:
  - N default.
  - Opcode constants OP_SUMA=0, OP_RESTA=1, OP_INC=2, OP_DEC=3, OP_AND=4, OP_OR=5, OP_NOT=6, OP_XOR=7, OP_SHL=8, OP_SHR=9, OP_RES_MIN=10.
  - FSM state encoding.
  - Flag bit indices.
- One sub-module, rr_arbitro: 2-way round-robin with inputs valid[1:0], advance, and output grant[1:0]. It holds the pointer.

Test Plan:
1. rst_n=0 for 3 cycles with both requests valid → ready=0, resp_valid=0, alu_select=0. Release → req0 granted first.
2. N=3, SETTLE=1; req0 op=0, a=3, b=5 → accepted at t, resp_valid at t+2, resultado=0, flags=1101 (ovf=1, cout=1, neg=0, zero=1), id=0.
3. req1 op=1, a=2, b=5 → resultado=5, flags=0010 (negativo=1, cout/ovf forced 0), id=1.
4. Both requesters valid continuously with resp_ready=1 → grant order 0,1,0,1; an op every 3 cycles.
5. req0 op=12 → resp_valid at t+1, resp_err=1, resultado=0, flags=0, alu_select unchanged.
6. Hold resp_ready=0 for 4 cycles with req1 valid → resp stable, req1_ready=0. Then rst_n=0 during EXEC of a new op → next cycle IDLE, resp_valid=0, pointer=0.
